// File: rtl/back_icon_channel_sched.sv
// Icon transfer scheduler: buffers dispatch requests in order and places each onto a free
// broadcast channel once it has no source or receiver conflict with channels in flight.
module back_icon_channel_sched #(
    parameter int NUM_ICON_CHANNELS = 4,
    parameter int NUM_RX            = 10,
    parameter int ADDR_W            = 8,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            req_src_addr_i,
    input  logic [NUM_RX-1:0]            req_receivers_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    output logic [ADDR_W-1:0]            ch_src_addr_o      [NUM_ICON_CHANNELS],
    output logic [NUM_RX-1:0]            ch_receiver_list_o [NUM_ICON_CHANNELS],
    output logic [NUM_ICON_CHANNELS-1:0] ch_active_o,
    input  logic [NUM_RX-1:0]            ch_success_list_i  [NUM_ICON_CHANNELS],
    output logic                         busy_o,
    output logic [15:0]                  retired_count_o
);

    // state     | meaning
    // CH_IDLE   | channel free, src/list held at 0
    // CH_ACTIVE | channel driving src and outstanding receiver list
    typedef enum logic {CH_IDLE = 1'b0, CH_ACTIVE = 1'b1} ch_state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CH_W  = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;
    localparam int RET_W = $clog2(NUM_ICON_CHANNELS + 2);

    ch_state_t         ch_state     [NUM_ICON_CHANNELS];
    ch_state_t         ch_state_nxt [NUM_ICON_CHANNELS];
    logic [ADDR_W-1:0] src_nxt      [NUM_ICON_CHANNELS];
    logic [NUM_RX-1:0] list_nxt     [NUM_ICON_CHANNELS];
    logic [NUM_RX-1:0] masked;

    logic [ADDR_W-1:0] fifo_src [FIFO_DEPTH];
    logic [NUM_RX-1:0] fifo_rx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_empty, fifo_full;
    logic              push, pop, empty_pop, alloc;
    logic              conflict, free_found;
    logic [CH_W-1:0]   free_idx;
    logic [ADDR_W-1:0] head_src;
    logic [NUM_RX-1:0] head_rx;
    logic [RET_W-1:0]  retire_cnt;

    assign fifo_empty  = (fifo_count == '0);
    assign fifo_full   = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign req_ready_o = !fifo_full;
    assign push        = req_valid_i && req_ready_o;
    assign head_src    = fifo_src[rd_ptr];
    assign head_rx     = fifo_rx[rd_ptr];
    assign busy_o      = !fifo_empty || (|ch_active_o);

    always_comb begin
        for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
            ch_active_o[k] = (ch_state[k] == CH_ACTIVE);
        end
    end

    // Conflicts are judged only against registered channel state, so a channel
    // retiring this cycle still blocks until the next one.
    always_comb begin
        conflict   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
            if (ch_state[k] == CH_ACTIVE) begin
                if ((ch_src_addr_o[k] == head_src) ||
                    ((head_rx & ch_receiver_list_o[k]) != '0)) begin
                    conflict = 1'b1;
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = CH_W'(k);
            end
        end
        empty_pop = !fifo_empty && (head_rx == '0);
        alloc     = !fifo_empty && (head_rx != '0) && free_found && !conflict;
        pop       = empty_pop || alloc;
    end

    always_comb begin
        retire_cnt = '0;
        masked     = '0;
        for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
            ch_state_nxt[k] = ch_state[k];
            src_nxt[k]      = ch_src_addr_o[k];
            list_nxt[k]     = ch_receiver_list_o[k];
            if (ch_state[k] == CH_ACTIVE) begin
                masked = ch_receiver_list_o[k] & ~ch_success_list_i[k];
                if (masked == '0) begin
                    ch_state_nxt[k] = CH_IDLE;
                    src_nxt[k]      = '0;
                    list_nxt[k]     = '0;
                    retire_cnt      = retire_cnt + RET_W'(1);
                end else begin
                    list_nxt[k] = masked;
                end
            end else if (alloc && (free_idx == CH_W'(k))) begin
                ch_state_nxt[k] = CH_ACTIVE;
                src_nxt[k]      = head_src;
                list_nxt[k]     = head_rx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
                ch_state[k]           <= CH_IDLE;
                ch_src_addr_o[k]      <= '0;
                ch_receiver_list_o[k] <= '0;
            end
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            fifo_count      <= '0;
            retired_count_o <= '0;
        end else begin
            for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
                ch_state[k]           <= ch_state_nxt[k];
                ch_src_addr_o[k]      <= src_nxt[k];
                ch_receiver_list_o[k] <= list_nxt[k];
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count      <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            retired_count_o <= retired_count_o + 16'(retire_cnt) + 16'(empty_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src[wr_ptr] <= req_src_addr_i;
            fifo_rx[wr_ptr]  <= req_receivers_i;
        end
    end

endmodule

// File: tb/tb_back_icon_channel_sched.sv
// Randomized bench for back_icon_channel_sched against a queue-based reference model,
// plus a few directed scenarios with hand-computed expectations.
module tb_back_icon_channel_sched;

    localparam int NCH   = 4;
    localparam int NRX   = 10;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]  src;
        logic [NRX-1:0] rx;
    } req_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [AW-1:0]  req_src;
    logic [NRX-1:0] req_rx;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  ch_src  [NCH];
    logic [NRX-1:0] ch_list [NCH];
    logic [NCH-1:0] ch_active;
    logic [NRX-1:0] succ    [NCH];
    logic           busy;
    logic [15:0]    retired;

    int n_checks = 0;
    int n_errors = 0;

    req_t           m_q[$];
    logic           m_act  [NCH];
    logic [AW-1:0]  m_src  [NCH];
    logic [NRX-1:0] m_list [NCH];
    int unsigned    m_retired;

    back_icon_channel_sched #(
        .NUM_ICON_CHANNELS(NCH), .NUM_RX(NRX), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_src_addr_i(req_src), .req_receivers_i(req_rx), .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .ch_src_addr_o(ch_src), .ch_receiver_list_o(ch_list), .ch_active_o(ch_active),
        .ch_success_list_i(succ),
        .busy_o(busy), .retired_count_o(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic any_act;
        any_act = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("active%0d", k), 32'(ch_active[k]), 32'(m_act[k]));
            chk($sformatf("src%0d", k),    32'(ch_src[k]),    32'(m_src[k]));
            chk($sformatf("list%0d", k),   32'(ch_list[k]),   32'(m_list[k]));
            any_act |= m_act[k];
        end
        chk("ready",   32'(req_ready), 32'(m_q.size() < DEPTH));
        chk("busy",    32'(busy),      32'((m_q.size() > 0) || any_act));
        chk("retired", 32'(retired),   m_retired & 32'hFFFF);
    endtask

    // Reference: one clock edge of the scheduling rules, applied to the queue/array model.
    task automatic model_edge(input logic rst, input logic v, input req_t r,
                              input logic [NRX-1:0] s [NCH]);
        logic   can_push, do_alloc, do_empty, blocked;
        int     idle;
        req_t   head;
        logic [NRX-1:0] rem;
        if (rst) begin
            m_q.delete();
            for (int k = 0; k < NCH; k++) begin
                m_act[k] = 1'b0; m_src[k] = '0; m_list[k] = '0;
            end
            m_retired = 0;
            return;
        end
        can_push = v && (m_q.size() < DEPTH);
        do_alloc = 1'b0;
        do_empty = 1'b0;
        idle     = -1;
        head     = '0;
        if (m_q.size() > 0) begin
            head = m_q[0];
            if (head.rx == '0) begin
                do_empty = 1'b1;
            end else begin
                blocked = 1'b0;
                for (int k = NCH - 1; k >= 0; k--) begin
                    if (!m_act[k]) idle = k;
                    else if (m_src[k] == head.src || (m_list[k] & head.rx) != '0) blocked = 1'b1;
                end
                do_alloc = (idle >= 0) && !blocked;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (m_act[k]) begin
                rem = m_list[k] & ~s[k];
                if (rem == '0) begin
                    m_act[k] = 1'b0; m_src[k] = '0; m_list[k] = '0;
                    m_retired++;
                end else begin
                    m_list[k] = rem;
                end
            end
        end
        if (do_empty) m_retired++;
        if (do_alloc) begin
            m_act[idle] = 1'b1; m_src[idle] = head.src; m_list[idle] = head.rx;
        end
        if (do_empty || do_alloc) void'(m_q.pop_front());
        if (can_push) m_q.push_back(r);
    endtask

    // One cycle: check current state, drive this cycle's inputs, advance the model.
    task automatic cycle(input logic rst, input logic v, input logic [AW-1:0] s,
                         input logic [NRX-1:0] r, input logic [NCH-1:0][NRX-1:0] sc);
        logic [NRX-1:0] sa [NCH];
        req_t rq;
        @(negedge clk);
        compare_all();
        reset_n   = !rst;
        req_valid = v;
        req_src   = s;
        req_rx    = r;
        for (int k = 0; k < NCH; k++) begin
            succ[k] = sc[k];
            sa[k]   = sc[k];
        end
        rq.src = s;
        rq.rx  = r;
        model_edge(rst, v, rq, sa);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, '0, '0, '0);
    endtask

    logic [NCH-1:0][NRX-1:0] sc;
    logic [15:0]             cnt0;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_rx    = '0;
        for (int k = 0; k < NCH; k++) succ[k] = '0;
        m_retired = 0;
        for (int k = 0; k < NCH; k++) begin
            m_act[k] = 1'b0; m_src[k] = '0; m_list[k] = '0;
        end
        @(posedge clk);
        cycle(1'b1, 1'b0, '0, '0, '0);

        // Basic transfer
        cycle(1'b0, 1'b1, 8'd3, 10'h003, '0);
        idle_cycle();
        sc = '0; sc[0] = 10'h001;
        cycle(1'b0, 1'b0, '0, '0, sc);
        chk("t1_active", 32'(ch_active), 32'h1);
        chk("t1_list",   32'(ch_list[0]), 32'h003);
        sc = '0; sc[0] = 10'h002;
        cycle(1'b0, 1'b0, '0, '0, sc);
        chk("t1_list2",  32'(ch_list[0]), 32'h002);
        idle_cycle();
        chk("t1_idle",   32'(ch_active), 32'h0);
        chk("t1_ret",    32'(retired), 32'd1);

        // Two retires plus an empty pop in the same cycle
        cycle(1'b0, 1'b1, 8'd1, 10'h001, '0);
        cycle(1'b0, 1'b1, 8'd2, 10'h002, '0);
        idle_cycle();
        cycle(1'b0, 1'b1, 8'd7, 10'h000, '0);
        sc = '0; sc[0] = 10'h001; sc[1] = 10'h002;
        cycle(1'b0, 1'b0, '0, '0, sc);
        chk("t5_pre_active", 32'(ch_active), 32'h3);
        cnt0 = retired;
        idle_cycle();
        chk("t5_ret_plus3", 32'(retired), 32'(cnt0 + 16'd3));

        // Randomized traffic with conflicts, full FIFO and occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic           rst, v;
            logic [AW-1:0]  s;
            logic [NRX-1:0] r;
            rst = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 9) < 7);
            s   = AW'($urandom_range(0, 5));
            case ($urandom_range(0, 9))
                0:       r = '0;
                1, 2:    r = NRX'($urandom) | (NRX'(1) << $urandom_range(0, NRX - 1));
                default: r = (NRX'(1) << $urandom_range(0, NRX - 1));
            endcase
            for (int k = 0; k < NCH; k++) begin
                sc[k] = ($urandom_range(0, 3) == 0) ? NRX'($urandom) : '0;
            end
            cycle(rst, v, s, r, sc);
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
